// File: rtl/board_game_pkg.sv
// Shared types for the N x N, K-in-a-row game controller: FSM state codes,
// cell encodings and winner encodings.
package board_game_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P1_TURN = 4'd1,
        P2_TURN = 4'd2,
        CHECK   = 4'd3,
        WIN     = 4'd4,
        DRAW    = 4'd5
    } state_t;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t P1    = 2'b01;
    localparam cell_t P2    = 2'b10;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/board_game_line_checker.sv
// Purpose: flags any horizontal, vertical, diagonal or anti-diagonal run of K cells owned by player.
// Latency: purely combinational. Backpressure: none, evaluated continuously on the registered board.
module line_checker
    import board_game_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic [2*N*N-1:0] board,
    input  cell_t            player,
    output logic             win
);

    logic [N*N-1:0] hit;
    logic           run;

    for (genvar i = 0; i < N*N; i++) begin : g_hit
        assign hit[i] = (board[2*i +: 2] == player);
    end

    // Loop bounds keep every window inside the board, so no index ever leaves the array.
    always_comb begin
        win = 1'b0;
        run = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c <= N - K; c++) begin
                run = 1'b1;
                for (int k = 0; k < K; k++) run &= hit[r*N + c + k];
                win |= run;
            end
        end
        for (int r = 0; r <= N - K; r++) begin
            for (int c = 0; c < N; c++) begin
                run = 1'b1;
                for (int k = 0; k < K; k++) run &= hit[(r + k)*N + c];
                win |= run;
            end
        end
        for (int r = 0; r <= N - K; r++) begin
            for (int c = 0; c <= N - K; c++) begin
                run = 1'b1;
                for (int k = 0; k < K; k++) run &= hit[(r + k)*N + c + k];
                win |= run;
            end
        end
        for (int r = 0; r <= N - K; r++) begin
            for (int c = K - 1; c < N; c++) begin
                run = 1'b1;
                for (int k = 0; k < K; k++) run &= hit[(r + k)*N + c - k];
                win |= run;
            end
        end
    end

endmodule

// File: rtl/board_game_ctrl.sv
// Purpose: two-player N x N board game controller (board, cursor, turns, turn timer, win/draw); BOARD_GAME_AUTOMOVE_EN auto-places on timeout.
// Latency: button edge acted on at the next clk edge; CHECK adds one cycle after each placement.
// Backpressure: none; button events outside the states that use them are dropped.
module board_game_ctrl
    import board_game_pkg::*;
#(
    parameter int N            = 3,
    parameter int K            = 3,
    parameter int CLK_HZ       = 50_000_000,
    parameter int TURN_SECONDS = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    move_next,
    input  logic                    place,
    output logic [2*N*N-1:0]        board,
    output logic [$clog2(N*N)-1:0]  cursor,
    output logic [3:0]              state,
    output logic                    led_p1,
    output logic                    led_p2,
    output logic [7:0]              timer_count,
    output logic [1:0]              winner,
    output logic                    illegal_move
);

    localparam int CELLS = N*N;
    localparam int CW    = $clog2(CELLS);
    localparam int PW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST_CELL   = CW'(CELLS - 1);
    localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_HZ - 1);
    localparam logic [7:0]    TURN_RELOAD = 8'(TURN_SECONDS);

    state_t            state_q, state_d;
    logic [2*CELLS-1:0] board_q, board_d;
    logic [CW-1:0]     cursor_q, cursor_d;
    logic [1:0]        winner_q, winner_d;
    logic [7:0]        timer_q, timer_d;
    logic [PW-1:0]     presc_q, presc_d;
    cell_t             mover_q, mover_d;
    logic              illegal_q, illegal_d;
    logic              start_q, next_q, place_q;

    logic   start_ev, next_ev, place_ev;
    logic   tick, timeout, full, line_win;
    cell_t  turn_mark, cur_cell;

    assign start_ev  = start & ~start_q;
    assign next_ev   = move_next & ~next_q;
    assign place_ev  = place & ~place_q;
    assign tick      = (presc_q == PRESC_MAX);
    assign timeout   = tick && (timer_q == 8'd0);
    assign turn_mark = (state_q == P1_TURN) ? P1 : P2;
    assign cur_cell  = board_q[2*cursor_q +: 2];

    always_comb begin
        full = 1'b1;
        for (int i = 0; i < CELLS; i++) begin
            if (board_q[2*i +: 2] == EMPTY) full = 1'b0;
        end
    end

`ifdef BOARD_GAME_AUTOMOVE_EN
    logic [CW-1:0] auto_idx;

    always_comb begin
        auto_idx = '0;
        for (int i = CELLS - 1; i >= 0; i--) begin
            if (board_q[2*i +: 2] == EMPTY) auto_idx = CW'(i);
        end
    end
`endif

    line_checker #(.N(N), .K(K)) u_line_checker (
        .board  (board_q),
        .player (mover_q),
        .win    (line_win)
    );

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cursor_d  = cursor_q;
        winner_d  = winner_q;
        timer_d   = timer_q;
        presc_d   = presc_q;
        mover_d   = mover_q;
        illegal_d = 1'b0;

        case (state_q)
            IDLE, WIN, DRAW: ;
            P1_TURN, P2_TURN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && timer_q != 8'd0) timer_d = timer_q - 8'd1;
                if (place_ev) begin
                    if (cur_cell == EMPTY) begin
                        board_d[2*cursor_q +: 2] = turn_mark;
                        mover_d = turn_mark;
                        state_d = CHECK;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else if (timeout) begin
`ifdef BOARD_GAME_AUTOMOVE_EN
                    board_d[2*auto_idx +: 2] = turn_mark;
                    mover_d = turn_mark;
                    state_d = CHECK;
`else
                    state_d = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
                    timer_d = TURN_RELOAD;
                    presc_d = '0;
`endif
                end else if (next_ev) begin
                    cursor_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
                end
            end
            CHECK: begin
                if (line_win) begin
                    state_d  = WIN;
                    winner_d = mover_q;
                end else if (full) begin
                    state_d = DRAW;
                end else begin
                    state_d = (mover_q == P1) ? P2_TURN : P1_TURN;
                    timer_d = TURN_RELOAD;
                    presc_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new game overrides whatever the turn logic decided this cycle.
        if (start_ev && state_q inside {IDLE, P1_TURN, P2_TURN, WIN, DRAW}) begin
            state_d   = P1_TURN;
            board_d   = '0;
            cursor_d  = '0;
            winner_d  = WINNER_NONE;
            timer_d   = TURN_RELOAD;
            presc_d   = '0;
            illegal_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            board_q   <= '0;
            cursor_q  <= '0;
            winner_q  <= WINNER_NONE;
            timer_q   <= TURN_RELOAD;
            presc_q   <= '0;
            mover_q   <= EMPTY;
            illegal_q <= 1'b0;
            start_q   <= 1'b0;
            next_q    <= 1'b0;
            place_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            cursor_q  <= cursor_d;
            winner_q  <= winner_d;
            timer_q   <= timer_d;
            presc_q   <= presc_d;
            mover_q   <= mover_d;
            illegal_q <= illegal_d;
            start_q   <= start;
            next_q    <= move_next;
            place_q   <= place;
        end
    end

    assign board        = board_q;
    assign cursor       = cursor_q;
    assign state        = state_q;
    assign led_p1       = (state_q == P1_TURN);
    assign led_p2       = (state_q == P2_TURN);
    assign timer_count  = timer_q;
    assign winner       = winner_q;
    assign illegal_move = illegal_q;

endmodule
